// File: rtl/i2c_pkg.sv
// I2C byte controller shared definitions.
// Command codes and sequencer states.
package i2c_pkg;
  localparam int DATA_W = 8;
  localparam int CMD_W  = 3;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd2;
  localparam logic [2:0] CMD_READ  = 3'd3;
  localparam logic [2:0] CMD_STOP  = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START_A,
    ST_START_B,
    ST_BIT_TX,
    ST_BIT_RX,
    ST_ACK_TX,
    ST_ACK_RX,
    ST_STOP_A,
    ST_STOP_B,
    ST_HOLD
  } state_t;
endpackage

// File: rtl/i2c_master_byte_ctrl_if.sv
// Command, clock-generator and bus signals
// of the I2C byte controller.
interface i2c_master_byte_ctrl_if #(
  parameter int CMD_W = 3
);
  logic [7:0]       prescaler_i;
  logic             scl_i;
  logic [7:0]       counter_detect_edge_i;
  logic [CMD_W-1:0] cmd_i;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [7:0]       data_i;
  logic             ack_i;
  logic             sda_i;
  logic             sda_oe_o;
  logic             scl_oe_o;
  logic [7:0]       data_o;
  logic             ack_o;
  logic             done_o;
  logic             err_o;
  logic             arb_lost_o;
  logic             busy_o;

  modport master (
    input  prescaler_i, scl_i,
    input  counter_detect_edge_i,
    input  cmd_i, cmd_valid_i,
    input  data_i, ack_i, sda_i,
    output cmd_ready_o,
    output sda_oe_o, scl_oe_o,
    output data_o, ack_o, done_o,
    output err_o, arb_lost_o, busy_o
  );

  modport slave (
    output prescaler_i, scl_i,
    output counter_detect_edge_i,
    output cmd_i, cmd_valid_i,
    output data_i, ack_i, sda_i,
    input  cmd_ready_o,
    input  sda_oe_o, scl_oe_o,
    input  data_o, ack_o, done_o,
    input  err_o, arb_lost_o, busy_o
  );
endinterface

// File: rtl/i2c_phase_decode.sv
// SCL phase strobes derived from the clock
// generator down-counter and prescaler.
module i2c_phase_decode (
  input  logic       scl,
  input  logic [7:0] cnt,
  input  logic [7:0] presc,
  output logic       mid_high,
  output logic       mid_low,
  output logic       fall
);
  logic [8:0] hi_pt;

  assign hi_pt = {1'b0, presc}
               + {2'b00, presc[7:1]};

  assign mid_high = scl
                  & ({1'b0, cnt} == hi_pt);
  assign mid_low  = ~scl
                  & (cnt == {1'b0, presc[7:1]});
  assign fall     = scl & (cnt == presc);
endmodule

// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C master sequencer: START,
// WRITE, READ and STOP over open-drain enables.
module i2c_master_byte_ctrl #(
  parameter int CMD_W  = 3,
  parameter int DATA_W = 8
) (
  input logic i2c_core_clock_i,
  input logic reset_bit_i,
  i2c_master_byte_ctrl_if.master bus
);
  import i2c_pkg::*;

  state_t           state;
  logic             bus_owned, pend, half;
  logic             hold_low, ack_l;
  logic [2:0]       idx;
  logic [DATA_W-1:0] tx, rx, rdata;
  logic             sda_oe, scl_oe, ack_q;
  logic             done, err, arb, busy;
  logic             mid_high, mid_low, fall;
  logic             ready, take, in_hold;
  logic             is_nop, is_start, is_bad;
  logic             g_wr, g_rd, g_stop;
  logic [CMD_W-1:0] cmd;

  i2c_phase_decode u_phase (
    .scl      (bus.scl_i),
    .cnt      (bus.counter_detect_edge_i),
    .presc    (bus.prescaler_i),
    .mid_high (mid_high),
    .mid_low  (mid_low),
    .fall     (fall)
  );

  assign cmd      = bus.cmd_i;
  assign in_hold  = (state == ST_HOLD);
  assign ready    = (in_hold | (state == ST_IDLE))
                  & ~done;
  assign take     = bus.cmd_valid_i & ready;
  assign is_nop   = (cmd == CMD_W'(CMD_NOP));
  assign is_start = (cmd == CMD_W'(CMD_START));
  assign g_wr     = in_hold
                  & (cmd == CMD_W'(CMD_WRITE));
  assign g_rd     = in_hold
                  & (cmd == CMD_W'(CMD_READ));
  assign g_stop   = in_hold
                  & (cmd == CMD_W'(CMD_STOP));
  assign is_bad   = ~(is_nop | is_start | g_wr
                    | g_rd | g_stop);

  assign bus.cmd_ready_o = ready;
  assign bus.sda_oe_o    = sda_oe;
  assign bus.scl_oe_o    = scl_oe;
  assign bus.data_o      = rdata;
  assign bus.ack_o       = ack_q;
  assign bus.done_o      = done;
  assign bus.err_o       = err;
  assign bus.arb_lost_o  = arb;
  assign bus.busy_o      = busy;

  always_ff @(posedge i2c_core_clock_i) begin
    if (reset_bit_i) begin
      state     <= ST_IDLE;
      bus_owned <= 1'b0;
      pend      <= 1'b0;
      half      <= 1'b0;
      hold_low  <= 1'b0;
      ack_l     <= 1'b0;
      idx       <= 3'd0;
      tx        <= '0;
      rx        <= '0;
      rdata     <= '0;
      sda_oe    <= 1'b0;
      scl_oe    <= 1'b0;
      ack_q     <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      arb       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      arb    <= 1'b0;
      scl_oe <= bus_owned
              & (~bus.scl_i | hold_low);
      if (done) busy <= 1'b0;
      if (take) begin
        hold_low <= 1'b0;
        half     <= 1'b0;
        pend     <= 1'b0;
        idx      <= 3'd7;
        unique case (1'b1)
          is_nop: ;
          is_start: begin
            busy  <= 1'b1;
            state <= in_hold ? ST_START_A
                             : ST_START_B;
          end
          g_wr: begin
            busy  <= 1'b1;
            tx    <= bus.data_i;
            state <= ST_BIT_TX;
          end
          g_rd: begin
            busy  <= 1'b1;
            ack_l <= bus.ack_i;
            state <= ST_BIT_RX;
          end
          g_stop: begin
            busy  <= 1'b1;
            state <= ST_STOP_A;
          end
          is_bad: begin
            busy <= 1'b1;
            done <= 1'b1;
            err  <= 1'b1;
          end
        endcase
      end else begin
        unique case (state)
          ST_START_A:
            if (mid_low) begin
              sda_oe <= 1'b0;
              state  <= ST_START_B;
            end
          ST_START_B:
            if (pend) begin
              pend  <= 1'b0;
              done  <= 1'b1;
              state <= ST_HOLD;
            end else if (mid_high) begin
              sda_oe    <= 1'b1;
              bus_owned <= 1'b1;
              pend      <= 1'b1;
            end
          ST_BIT_TX:
            if (mid_low) begin
              sda_oe <= ~tx[idx];
              half   <= 1'b1;
            end else if (mid_high && half) begin
              half <= 1'b0;
              // a released SDA seen low means another master won
              if (!sda_oe && !bus.sda_i) begin
                sda_oe    <= 1'b0;
                bus_owned <= 1'b0;
                state     <= ST_IDLE;
                done      <= 1'b1;
                arb       <= 1'b1;
              end else if (idx == 3'd0) begin
                state <= ST_ACK_RX;
              end else begin
                idx <= idx - 3'd1;
              end
            end
          ST_ACK_RX:
            if (pend) begin
              pend  <= 1'b0;
              done  <= 1'b1;
              state <= ST_HOLD;
            end else if (mid_low) begin
              sda_oe <= 1'b0;
              half   <= 1'b1;
            end else if (mid_high && half) begin
              half  <= 1'b0;
              ack_q <= bus.sda_i;
              pend  <= 1'b1;
            end
          ST_BIT_RX:
            if (mid_low) begin
              sda_oe <= 1'b0;
              half   <= 1'b1;
            end else if (mid_high && half) begin
              half <= 1'b0;
              rx   <= {rx[DATA_W-2:0], bus.sda_i};
              if (idx == 3'd0) state <= ST_ACK_TX;
              else idx <= idx - 3'd1;
            end
          ST_ACK_TX:
            if (pend) begin
              pend  <= 1'b0;
              done  <= 1'b1;
              rdata <= rx;
              state <= ST_HOLD;
            end else if (mid_low) begin
              sda_oe <= ~ack_l;
              half   <= 1'b1;
            end else if (mid_high && half) begin
              half <= 1'b0;
              pend <= 1'b1;
            end
          ST_STOP_A:
            if (mid_low) begin
              sda_oe <= 1'b1;
              state  <= ST_STOP_B;
            end
          ST_STOP_B:
            if (pend) begin
              pend  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else if (mid_high) begin
              sda_oe    <= 1'b0;
              bus_owned <= 1'b0;
              pend      <= 1'b1;
            end
          ST_HOLD:
            if (fall) hold_low <= 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Directed bench for the I2C byte controller
// with a free-running clock generator model, P=4.
module tb_i2c_master_byte_ctrl;
  localparam logic [7:0] P   = 8'd4;
  localparam logic [7:0] TOP = 8'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       slv = 1'b0;
  logic [7:0] cnt;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  logic [8:0] oe, slo, shi;
  logic [7:0] dmid;
  int         ncyc;

  i2c_master_byte_ctrl_if bus ();

  i2c_master_byte_ctrl dut (
    .i2c_core_clock_i (clk),
    .reset_bit_i      (rst),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || cnt == 8'd0) cnt <= TOP;
    else cnt <= cnt - 8'd1;
  end

  assign bus.prescaler_i           = P;
  assign bus.counter_detect_edge_i = cnt;
  assign bus.scl_i                 = (cnt >= P);
  assign bus.sda_i = ~bus.sda_oe_o & ~slv;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_cnt(input logic [7:0] v);
    int n = 0;
    @(negedge clk);
    while (cnt !== v && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (cnt !== v) chk("cnt_timeout", 32'(cnt), 32'(v));
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (bus.done_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.done_o !== 1'b1)
      chk("done_timeout", 32'(bus.done_o), 32'(1));
  endtask

  task automatic issue(input logic [2:0] c,
                       input logic [7:0] d,
                       input logic a);
    int n = 0;
    @(negedge clk);
    bus.cmd_i = c;
    bus.data_i = d;
    bus.ack_i = a;
    bus.cmd_valid_i = 1'b1;
    while (bus.cmd_ready_o !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (bus.cmd_ready_o !== 1'b1)
      chk("ready_timeout", 32'(bus.cmd_ready_o), 32'(1));
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_i = 3'd0;
  endtask

  // Nine SCL slots of one WRITE or READ with a cooperating slave.
  task automatic run_byte(input logic [2:0] c,
                          input logic [7:0] d,
                          input logic a,
                          input logic [7:0] sb,
                          input logic sack,
                          output logic [8:0] o_oe,
                          output logic [8:0] o_slo,
                          output logic [8:0] o_shi,
                          output logic [7:0] o_dmid,
                          output int o_cyc);
    int t0;
    issue(c, d, a);
    t0 = cyc;
    o_dmid = 8'h00;
    for (int k = 0; k < 9; k++) begin
      wait_cnt(8'd1);
      o_oe[8-k]  = bus.sda_oe_o;
      o_slo[8-k] = bus.scl_oe_o;
      if (k < 8) begin
        slv = (c == 3'd3) ? ~sb[7-k] : 1'b0;
      end else begin
        slv = (c == 3'd2) ? ~sack : 1'b0;
        o_dmid = bus.data_o;
      end
      wait_cnt(8'd5);
      o_shi[8-k] = bus.scl_oe_o;
    end
    wait_done();
    o_cyc = cyc - t0;
    slv = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sda_oe"}, 32'(bus.sda_oe_o), 32'(0));
    chk({tag, "_scl_oe"}, 32'(bus.scl_oe_o), 32'(0));
    chk({tag, "_data"},   32'(bus.data_o),   32'(0));
    chk({tag, "_ack"},    32'(bus.ack_o),    32'(1));
    chk({tag, "_done"},   32'(bus.done_o),   32'(0));
    chk({tag, "_err"},    32'(bus.err_o),    32'(0));
    chk({tag, "_arb"},    32'(bus.arb_lost_o), 32'(0));
    chk({tag, "_busy"},   32'(bus.busy_o),   32'(0));
    chk({tag, "_ready"},  32'(bus.cmd_ready_o), 32'(1));
  endtask

  initial begin
    bus.cmd_i = 3'd0;
    bus.cmd_valid_i = 1'b0;
    bus.data_i = 8'h00;
    bus.ack_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    rst = 1'b0;

    // START from IDLE
    issue(3'd1, 8'h00, 1'b0);
    chk("start_busy", 32'(bus.busy_o), 32'(1));
    for (int n = 0; n < 40 && bus.sda_oe_o !== 1'b1; n++)
      @(negedge clk);
    chk("start_sda", 32'(bus.sda_oe_o), 32'(1));
    chk("start_cnt", 32'(cnt), 32'(5));
    chk("start_nodone", 32'(bus.done_o), 32'(0));
    @(negedge clk);
    chk("start_done", 32'(bus.done_o), 32'(1));
    chk("start_done_cnt", 32'(cnt), 32'(4));

    // WRITE 0xA5, slave ACKs
    run_byte(3'd2, 8'hA5, 1'b0, 8'h00, 1'b0,
             oe, slo, shi, dmid, ncyc);
    chk("wr_oe", 32'(oe), 32'(9'b010110100));
    chk("wr_scl_low", 32'(slo), 32'(9'h1FF));
    chk("wr_scl_high", 32'(shi), 32'(9'h000));
    chk("wr_ack", 32'(bus.ack_o), 32'(0));
    chk("wr_err", 32'(bus.err_o), 32'(0));
    chk("wr_cycles", 32'(ncyc), 32'(70));

    // READ 0x3C, master NACKs
    run_byte(3'd3, 8'h00, 1'b1, 8'h3C, 1'b0,
             oe, slo, shi, dmid, ncyc);
    chk("rd_oe", 32'(oe), 32'(9'h000));
    chk("rd_data_mid", 32'(dmid), 32'(8'h00));
    chk("rd_data", 32'(bus.data_o), 32'(8'h3C));
    chk("rd_err", 32'(bus.err_o), 32'(0));
    chk("rd_arb", 32'(bus.arb_lost_o), 32'(0));
    chk("rd_cycles", 32'(ncyc), 32'(70));

    // WRITE 0xFF, another master pulls SDA on bit 7
    issue(3'd2, 8'hFF, 1'b0);
    wait_cnt(8'd1);
    chk("arb_bit7_oe", 32'(bus.sda_oe_o), 32'(0));
    slv = 1'b1;
    wait_done();
    chk("arb_lost", 32'(bus.arb_lost_o), 32'(1));
    chk("arb_err", 32'(bus.err_o), 32'(0));
    chk("arb_cnt", 32'(cnt), 32'(5));
    chk("arb_sda", 32'(bus.sda_oe_o), 32'(0));
    slv = 1'b0;
    @(negedge clk);
    chk("arb_sda_next", 32'(bus.sda_oe_o), 32'(0));
    chk("arb_scl_next", 32'(bus.scl_oe_o), 32'(0));
    chk("arb_ready", 32'(bus.cmd_ready_o), 32'(1));
    chk("arb_busy", 32'(bus.busy_o), 32'(0));

    // STOP in IDLE is illegal
    issue(3'd4, 8'h00, 1'b0);
    chk("ill_done", 32'(bus.done_o), 32'(1));
    chk("ill_err", 32'(bus.err_o), 32'(1));
    chk("ill_arb", 32'(bus.arb_lost_o), 32'(0));
    chk("ill_sda", 32'(bus.sda_oe_o), 32'(0));
    chk("ill_scl", 32'(bus.scl_oe_o), 32'(0));
    @(negedge clk);
    chk("ill_done_end", 32'(bus.done_o), 32'(0));

    // START, WRITE 0x5A, STOP
    issue(3'd1, 8'h00, 1'b0);
    wait_done();
    chk("s2_sda", 32'(bus.sda_oe_o), 32'(1));
    run_byte(3'd2, 8'h5A, 1'b0, 8'h00, 1'b0,
             oe, slo, shi, dmid, ncyc);
    chk("w2_oe", 32'(oe), 32'(9'b101001010));
    chk("w2_ack", 32'(bus.ack_o), 32'(0));
    issue(3'd4, 8'h00, 1'b0);
    wait_cnt(8'd1);
    chk("stop_sda_low", 32'(bus.sda_oe_o), 32'(1));
    wait_done();
    chk("stop_sda_rel", 32'(bus.sda_oe_o), 32'(0));
    chk("stop_err", 32'(bus.err_o), 32'(0));
    wait_cnt(8'd2);
    chk("stop_scl_rel", 32'(bus.scl_oe_o), 32'(0));
    chk("stop_ready", 32'(bus.cmd_ready_o), 32'(1));
    chk("stop_busy", 32'(bus.busy_o), 32'(0));

    // Reset in the middle of a READ at bit 3
    issue(3'd1, 8'h00, 1'b0);
    wait_done();
    issue(3'd3, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) wait_cnt(8'd1);
    chk("mid_rd_data", 32'(bus.data_o), 32'(8'h3C));
    chk("mid_rd_scl", 32'(bus.scl_oe_o), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst1");
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
